// File: rtl/svm_linear_seq.sv
// Sequential linear SVM scorer: one feature*weight product per cycle, biased by INTERCEPT,
// result wrapped or saturated to ACC_W bits and held under a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready=1
// MAC   | accumulating feature[idx]*weight[idx], one term per cycle
// DONE  | result presented on out, out_valid=1 until out_ready
module svm_linear_seq #(
    parameter int                       NUM_FEAT  = 4,
    parameter int                       IN_W      = 4,
    parameter int                       W_W       = 8,
    parameter int                       ACC_W     = 13,
    parameter logic [NUM_FEAT*W_W-1:0]  WEIGHTS   = 32'h4949_B7B7,
    parameter int                       INTERCEPT = 1170,
    parameter bit                       SAT       = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_FEAT*IN_W-1:0] inp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out
);

    localparam int AW    = ACC_W + IN_W + W_W;
    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

    localparam logic signed [AW-1:0] BIAS    = AW'(INTERCEPT);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_FEAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [NUM_FEAT*IN_W-1:0] feat_q;
    logic signed [AW-1:0]     acc;
    logic [IDX_W-1:0]         idx;
    logic [ACC_W-1:0]         out_q;

    logic                     load;
    logic                     mac_en;
    logic                     last;
    logic [IN_W-1:0]          feat;
    logic [W_W-1:0]           wgt;
    logic signed [AW-1:0]     feat_ext;
    logic signed [AW-1:0]     wgt_ext;
    logic signed [AW-1:0]     prod;
    logic signed [AW-1:0]     acc_sum;
    logic [ACC_W-1:0]         result;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = MAC;
            MAC:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // output / control decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mac_en    = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            MAC:     mac_en    = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
        load = in_ready & in_valid;
    end

    assign last = (idx == IDX_LAST);

    // Feature is unsigned, weight signed: widen both to the accumulator width before multiplying.
    assign feat     = feat_q[idx*IN_W +: IN_W];
    assign wgt      = WEIGHTS[idx*W_W +: W_W];
    assign feat_ext = $signed({{(AW-IN_W){1'b0}}, feat});
    assign wgt_ext  = $signed({{(AW-W_W){wgt[W_W-1]}}, wgt});
    assign prod     = feat_ext * wgt_ext;
    assign acc_sum  = acc + prod;

    always_comb begin
        result = acc_sum[ACC_W-1:0];
        if (SAT) begin
            if (acc_sum > SAT_MAX) begin
                result = SAT_MAX[ACC_W-1:0];
            end else if (acc_sum < SAT_MIN) begin
                result = SAT_MIN[ACC_W-1:0];
            end
        end
    end

    // The last add writes the converted sum straight into out_q so it is ready on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_q <= '0;
            acc    <= '0;
            idx    <= '0;
            out_q  <= '0;
        end else if (load) begin
            feat_q <= inp;
            acc    <= BIAS;
            idx    <= '0;
        end else if (mac_en) begin
            acc <= acc_sum;
            idx <= last ? '0 : idx + IDX_W'(1);
            if (last) begin
                out_q <= result;
            end
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_svm_linear_seq.sv
// Directed plus randomized checks of svm_linear_seq against an arithmetic reference model,
// covering wrap and saturation variants and a single-feature instance.
module tb_svm_linear_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] inp;

    logic        rdy_d, rdy_w, rdy_s;
    logic        vld_d, vld_w, vld_s;
    logic [12:0] out_d;
    logic [9:0]  out_w;
    logic [9:0]  out_s;

    logic        in_valid1;
    logic        out_ready1;
    logic [3:0]  inp1;
    logic        rdy_1, vld_1;
    logic [12:0] out_1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    svm_linear_seq u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_d), .inp(inp),
        .out_valid(vld_d), .out_ready(out_ready), .out(out_d)
    );

    svm_linear_seq #(.ACC_W(10), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .inp(inp),
        .out_valid(vld_w), .out_ready(out_ready), .out(out_w)
    );

    svm_linear_seq #(.ACC_W(10), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .inp(inp),
        .out_valid(vld_s), .out_ready(out_ready), .out(out_s)
    );

    svm_linear_seq #(.NUM_FEAT(1), .WEIGHTS(8'hB7)) u_one (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(rdy_1), .inp(inp1),
        .out_valid(vld_1), .out_ready(out_ready1), .out(out_1)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: bias plus dot product, then wrap or clamp to aw signed bits.
    function automatic int model(input logic [15:0] x, input int aw, input bit sat);
        int w[4] = '{-73, -73, 73, 73};
        int s = 1170;
        int lo = -(1 << (aw - 1));
        int hi = (1 << (aw - 1)) - 1;
        for (int i = 0; i < 4; i++) begin
            int f = int'(x[i*4 +: 4]);
            s += f * w[i];
        end
        if (sat) begin
            if (s > hi) s = hi;
            if (s < lo) s = lo;
        end else begin
            s = s & ((1 << aw) - 1);
            if (s > hi) s -= (1 << aw);
        end
        return s;
    endfunction

    task automatic send(input logic [15:0] x, input int hold);
        int          lat;
        logic [12:0] hd;
        logic [9:0]  hw;
        logic [9:0]  hs;
        inp      = x;
        in_valid = 1'b1;
        check("ready_before_accept", 32'(rdy_d), 32'd1);
        step();
        in_valid = 1'b0;
        inp      = 16'($urandom);
        check("ready_after_accept", 32'(rdy_d), 32'd0);
        lat = 1;
        while (!vld_d && lat < 20) begin
            in_valid  = (lat == 2);
            out_ready = (lat == 3);
            inp       = 16'($urandom);
            step();
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("latency", lat, 32'd5);
        check("out_default", 32'($signed(out_d)), model(x, 13, 1'b0));
        check("out_wrap10", 32'($signed(out_w)), model(x, 10, 1'b0));
        check("out_sat10", 32'($signed(out_s)), model(x, 10, 1'b1));
        check("valid_wrap_sat", 32'({vld_w, vld_s}), 32'd3);
        hd = out_d;
        hw = out_w;
        hs = out_s;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            inp      = 16'($urandom);
            step();
            check("hold_out", 32'({out_d, out_w, out_s}), 32'({hd, hw, hs}));
            check("hold_flags", 32'({vld_d, rdy_d, rdy_w, rdy_s}), 32'b1000);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        check("post_handshake", 32'({rdy_d, vld_d, rdy_w, rdy_s}), 32'b1011);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        bit saw;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        inp        = 16'h0000;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        inp1       = 4'h0;
        step();
        step();
        check("reset_default", 32'({rdy_d, vld_d, out_d}), 32'({1'b1, 1'b0, 13'd0}));
        check("reset_one", 32'({rdy_1, vld_1, out_1}), 32'({1'b1, 1'b0, 13'd0}));

        // reset beats in_valid on the same edge
        in_valid = 1'b1;
        inp      = 16'hFFFF;
        step();
        check("reset_priority", 32'({rdy_d, vld_d}), 32'b10);
        rst      = 1'b0;
        in_valid = 1'b0;

        send(16'h0000, 0);
        send(16'hFFFF, 1);
        send(16'h00FF, 3);
        send(16'hFF00, 2);
        send(16'hF0F0, 0);
        repeat (6) send(16'($urandom), int'($urandom_range(0, 2)));

        // reset mid-MAC at T+2
        inp      = 16'h1234;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mac_abort_state", 32'({rdy_d, vld_d, out_d}), 32'({1'b1, 1'b0, 13'd0}));
        saw = 1'b0;
        repeat (8) begin
            step();
            if (vld_d !== 1'b0) saw = 1'b1;
        end
        check("mac_abort_no_valid", 32'(saw), 32'd0);
        send(16'h0000, 0);

        // reset while in DONE
        inp      = 16'h00FF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("done_reached", 32'(vld_d), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("done_abort_state", 32'({rdy_d, vld_d, out_d}), 32'({1'b1, 1'b0, 13'd0}));
        saw = 1'b0;
        repeat (6) begin
            step();
            if (vld_d !== 1'b0) saw = 1'b1;
        end
        check("done_abort_no_valid", 32'(saw), 32'd0);

        // single-feature instance: out_valid at T+2
        for (int n = 0; n < 4; n++) begin
            logic [3:0] x;
            x = (n == 0) ? 4'hF : 4'($urandom);
            inp1      = x;
            in_valid1 = 1'b1;
            step();
            in_valid1 = 1'b0;
            inp1      = 4'($urandom);
            check("one_t1_valid", 32'({rdy_1, vld_1}), 32'b00);
            step();
            check("one_t2_valid", 32'(vld_1), 32'd1);
            check("one_out", 32'($signed(out_1)), 1170 - 73 * int'(x));
            out_ready1 = 1'b1;
            step();
            out_ready1 = 1'b0;
            check("one_idle", 32'({rdy_1, vld_1}), 32'b10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/svm_linear_seq.md
SVM_LINEAR_SEQ -- requirements
Module: svm_linear_seq

Interface
REQ-001 Parameter NUM_FEAT, default 4: number of input features.
REQ-002 Parameter IN_W, default 4: unsigned width of each feature.
REQ-003 Parameter W_W, default 8: signed two's-complement width of each weight.
REQ-004 Parameter ACC_W, default 13: signed width of the result.
REQ-005 Parameter WEIGHTS, default {73, 73, -73, -73}: NUM_FEAT*W_W packed bits. Weight i occupies bits [i*W_W +: W_W], so weight 0 = -73.
REQ-006 Parameter INTERCEPT, default 1170: signed bias, sign-extended to the accumulator width.
REQ-007 Parameter SAT, default 0: 0 = wrap result to ACC_W bits, 1 = saturate result to the ACC_W signed range.
REQ-008 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-009 Port rst, input, 1: reset, synchronous and active-high.
REQ-010 Port in_valid, input, 1: input vector valid.
REQ-011 Port in_ready, output, 1: block can accept a vector.
REQ-012 Port inp, input, NUM_FEAT*IN_W: feature i at [i*IN_W +: IN_W].
REQ-013 Port out_valid, output, 1: result valid.
REQ-014 Port out_ready, input, 1: consumer accepts the result.
REQ-015 Port out, output, ACC_W: signed decision value.

Function
REQ-016 FSM states SHALL be IDLE, MAC and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE SHALL work as follows:
- Accept occurs on in_valid & in_ready in cycle T.
- inp is captured into an internal register.
- The accumulator is loaded with INTERCEPT.
- The feature index is cleared to 0.
- The FSM moves to MAC.
REQ-019 MAC SHALL add one product per cycle: acc += zero_ext(feature[idx]) * sext(weight[idx]), idx increments, and the last add (idx = NUM_FEAT-1) moves the FSM to DONE.
REQ-020 out_valid SHALL first assert in cycle T+NUM_FEAT+1 (5 cycles after accept for the defaults).
REQ-021 Changes on inp after accept SHALL NOT affect the result.
REQ-022 The internal accumulator SHALL be ACC_W+IN_W+W_W bits wide, so no intermediate overflow occurs for any legal parameters.
REQ-023 out SHALL be the final accumulator converted to ACC_W bits:
- SAT=0: low ACC_W bits.
- SAT=1: clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-024 out SHALL be registered and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 In DONE with out_ready=1, the FSM SHALL go to IDLE on the next edge; in_ready rises one cycle after the result handshake, and no same-cycle input accept occurs.
REQ-026 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT be accepted.
REQ-027 out_ready asserted outside DONE SHALL have no effect.
REQ-028 NUM_FEAT=1 SHALL be legal: one MAC cycle, out_valid at T+2.

Reset
REQ-029 While rst=1 at an edge, the next state SHALL be IDLE with in_ready=1, out_valid=0, out=0, accumulator=0 and index=0.
REQ-030 rst asserted in MAC or DONE SHALL abort the operation and discard the result, with no out_valid pulse following.
REQ-031 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-032 Defaults, inp=16'h0000 accepted at T -> out_valid at T+5, out=1170.
REQ-033 Defaults, inp=16'hFFFF -> out=1170.
REQ-034 Defaults, inp=16'h00FF -> out=-1020 (13'h1C04).
REQ-035 ACC_W=10, result range overflow cases:
- SAT=0: inp=16'hFF00 -> 288; inp=16'h00FF -> 4.
- SAT=1: inp=16'hFF00 -> 511; inp=16'h00FF -> -512.
REQ-036 Backpressure: out_ready=0 for 3 cycles after out_valid -> out stable, in_ready=0, new in_valid ignored; out_ready=1 -> in_ready=1 the following cycle.
REQ-037 rst pulsed at T+2 mid-MAC -> out_valid never asserts for that vector; in_ready=1 at T+3; next vector inp=16'h0000 yields 1170.
